// File: rtl/nn_smoothgrad_multi_if.sv
// Bus bundle for the multi-channel smoothing-gradient integrator.
// The master side drives gradient events and configuration and reads back
// the parameter values and per-channel status.
interface nn_smoothgrad_multi_if #(
    parameter int N  = 8,
    parameter int M  = 4,
    parameter int RW = 8
);
    logic           en;
    logic [M-1:0]   in_ss;
    logic [M-1:0]   sign;
    logic [M*N-1:0] out_init;
    logic [RW-1:0]  resistance;
    logic           mode;
    logic [M*N-1:0] out;
    logic [M-1:0]   upd_pos;
    logic [M-1:0]   upd_neg;
    logic [M-1:0]   sat_hi;
    logic [M-1:0]   sat_lo;

    modport master (
        output en, in_ss, sign, out_init, resistance, mode,
        input  out, upd_pos, upd_neg, sat_hi, sat_lo
    );

    modport slave (
        input  en, in_ss, sign, out_init, resistance, mode,
        output out, upd_pos, upd_neg, sat_hi, sat_lo
    );
endinterface

// File: rtl/nn_smoothgrad_multi.sv
// Multi-channel stochastic parameter integrator.
// Each channel keeps an N-bit parameter and two event counters. A parameter
// moves by one LSB only after more than RESISTANCE same-sign events have been
// seen; in cancellation mode an event first consumes a pending opposite-sign
// count. Parameters saturate at [MINVAL, MAXVAL] and never wrap.
module nn_smoothgrad_multi #(
    parameter int            N      = 8,
    parameter int            M      = 4,
    parameter int            RW     = 8,
    parameter logic [N-1:0]  MAXVAL = {N{1'b1}},
    parameter logic [N-1:0]  MINVAL = '0
) (
    input  logic                   clk,
    input  logic                   init,
    nn_smoothgrad_multi_if.slave   bus
);

    // Per-channel architectural state.
    logic [N-1:0]  val_q   [M];
    logic [RW-1:0] cp_q    [M];
    logic [RW-1:0] cn_q    [M];
    logic [M-1:0]  upd_pos_q;
    logic [M-1:0]  upd_neg_q;

    // Next-state candidates assuming EN=1 and no INIT.
    logic [N-1:0]  val_d   [M];
    logic [RW-1:0] cp_d    [M];
    logic [RW-1:0] cn_d    [M];
    logic [M-1:0]  upd_pos_d;
    logic [M-1:0]  upd_neg_d;

    // Loaded values are forced into the legal parameter range.
    function automatic logic [N-1:0] clamp_load(input logic [N-1:0] v);
        if (v > MAXVAL) begin
            return MAXVAL;
        end
        if (v < MINVAL) begin
            return MINVAL;
        end
        return v;
    endfunction

    // Per-channel event rules: saturation guard, optional cancellation,
    // then either a step (count reached) or a count increment.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            // NOTE: every output of this block gets a default first so that
            // no path leaves it unassigned, which would infer a latch.
            val_d[i]     = val_q[i];
            cp_d[i]      = cp_q[i];
            cn_d[i]      = cn_q[i];
            upd_pos_d[i] = 1'b0;
            upd_neg_d[i] = 1'b0;

            if (bus.in_ss[i]) begin
                if (!bus.sign[i]) begin
                    if (val_q[i] == MAXVAL) begin
                        // Positive event at the top bound is discarded.
                    end else if (bus.mode && (cn_q[i] != '0)) begin
                        cn_d[i] = cn_q[i] - 1'b1;
                    end else if (cp_q[i] >= bus.resistance) begin
                        val_d[i]     = val_q[i] + 1'b1;
                        cp_d[i]      = '0;
                        upd_pos_d[i] = 1'b1;
                    end else begin
                        // Cannot overflow: cp < resistance <= 2^RW-1 here.
                        cp_d[i] = cp_q[i] + 1'b1;
                    end
                end else begin
                    if (val_q[i] == MINVAL) begin
                        // Negative event at the bottom bound is discarded.
                    end else if (bus.mode && (cp_q[i] != '0)) begin
                        cp_d[i] = cp_q[i] - 1'b1;
                    end else if (cn_q[i] >= bus.resistance) begin
                        val_d[i]     = val_q[i] - 1'b1;
                        cn_d[i]      = '0;
                        upd_neg_d[i] = 1'b1;
                    end else begin
                        cn_d[i] = cn_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // State registers: INIT loads and clears, EN=0 freezes, else advance.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (init) begin
            // NOTE: the counter arrays are cleared explicitly on INIT; a
            // stale partial count would otherwise leak into the next run.
            for (int i = 0; i < M; i++) begin
                val_q[i] <= clamp_load(bus.out_init[i*N +: N]);
                cp_q[i]  <= '0;
                cn_q[i]  <= '0;
            end
            upd_pos_q <= '0;
            upd_neg_q <= '0;
        end else if (!bus.en) begin
            upd_pos_q <= '0;
            upd_neg_q <= '0;
        end else begin
            for (int i = 0; i < M; i++) begin
                val_q[i] <= val_d[i];
                cp_q[i]  <= cp_d[i];
                cn_q[i]  <= cn_d[i];
            end
            upd_pos_q <= upd_pos_d;
            upd_neg_q <= upd_neg_d;
        end
    end

    // Output packing and saturation flags, straight off the registers.
    for (genvar g = 0; g < M; g++) begin : g_chan
        assign bus.out[g*N +: N] = val_q[g];
        assign bus.sat_hi[g]     = (val_q[g] == MAXVAL);
        assign bus.sat_lo[g]     = (val_q[g] == MINVAL);
    end

    assign bus.upd_pos = upd_pos_q;
    assign bus.upd_neg = upd_neg_q;

endmodule

// File: tb/tb_nn_smoothgrad_multi.sv
// Self-checking bench for nn_smoothgrad_multi: directed scenarios followed by
// a randomized run, all compared every cycle against a behavioural model.
module tb_nn_smoothgrad_multi;
    localparam int N    = 8;
    localparam int M    = 4;
    localparam int RW   = 8;
    localparam int MAXV = 255;
    localparam int MINV = 0;

    logic clk  = 1'b0;
    logic init = 1'b1;
    int   errors = 0;
    int   checks = 0;

    // Behavioural model state: plain integers per channel.
    int         m_out [M];
    int         m_cp  [M];
    int         m_cn  [M];
    logic [M-1:0] m_up;
    logic [M-1:0] m_dn;

    always #5 clk = ~clk;

    nn_smoothgrad_multi_if #(.N(N), .M(M), .RW(RW)) bus ();

    nn_smoothgrad_multi #(.N(N), .M(M), .RW(RW)) dut (
        .clk  (clk),
        .init (init),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clampv(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    // Model of one clock edge, using the inputs as they stand at the edge.
    task automatic model_edge();
        int res;
        res  = int'(bus.resistance);
        m_up = '0;
        m_dn = '0;
        if (init) begin
            for (int i = 0; i < M; i++) begin
                m_out[i] = clampv(int'(bus.out_init[i*N +: N]));
                m_cp[i]  = 0;
                m_cn[i]  = 0;
            end
        end else if (bus.en) begin
            for (int i = 0; i < M; i++) begin
                if (bus.in_ss[i] && !bus.sign[i]) begin
                    if (m_out[i] == MAXV) begin
                    end else if (bus.mode && m_cn[i] > 0) begin
                        m_cn[i]--;
                    end else if (m_cp[i] >= res) begin
                        m_out[i]++; m_cp[i] = 0; m_up[i] = 1'b1;
                    end else begin
                        m_cp[i]++;
                    end
                end else if (bus.in_ss[i] && bus.sign[i]) begin
                    if (m_out[i] == MINV) begin
                    end else if (bus.mode && m_cp[i] > 0) begin
                        m_cp[i]--;
                    end else if (m_cn[i] >= res) begin
                        m_out[i]--; m_cn[i] = 0; m_dn[i] = 1'b1;
                    end else begin
                        m_cn[i]++;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [M*N-1:0] eo;
        logic [M-1:0]   eh;
        logic [M-1:0]   el;
        for (int i = 0; i < M; i++) begin
            eo[i*N +: N] = N'(m_out[i]);
            eh[i]        = (m_out[i] == MAXV);
            el[i]        = (m_out[i] == MINV);
        end
        check({tag, ".out"},     64'(bus.out),     64'(eo));
        check({tag, ".upd_pos"}, 64'(bus.upd_pos), 64'(m_up));
        check({tag, ".upd_neg"}, 64'(bus.upd_neg), 64'(m_dn));
        check({tag, ".sat_hi"},  64'(bus.sat_hi),  64'(eh));
        check({tag, ".sat_lo"},  64'(bus.sat_lo),  64'(el));
    endtask

    // One clock: edge, model update, sample 1 time unit later and compare.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Events on one channel for n cycles; counts observed pulses.
    task automatic events(input int ch, input logic sgn, input int n,
                          input string tag, output int pos_cnt, output int neg_cnt);
        pos_cnt = 0;
        neg_cnt = 0;
        bus.in_ss = '0;
        bus.in_ss[ch] = 1'b1;
        bus.sign = '0;
        bus.sign[ch] = sgn;
        for (int k = 0; k < n; k++) begin
            cyc(tag);
            pos_cnt += int'(bus.upd_pos[ch]);
            neg_cnt += int'(bus.upd_neg[ch]);
        end
        bus.in_ss = '0;
    endtask

    task automatic do_init(input logic [M*N-1:0] vals);
        bus.out_init = vals;
        init = 1'b1;
        cyc("init");
        init = 1'b0;
    endtask

    function automatic logic [N-1:0] ch_out(input int ch);
        return bus.out[ch*N +: N];
    endfunction

    initial begin
        logic [M*N-1:0] init_v;
        int pc, nc, pc2, nc2;
        init_v = {8'd10, 8'd50, 8'd254, 8'd100};

        bus.en = 1'b0; bus.in_ss = '0; bus.sign = '0;
        bus.out_init = init_v; bus.resistance = 8'd3; bus.mode = 1'b0;

        // Reset state.
        do_init(init_v);
        check("reset.out0", 64'(ch_out(0)), 64'd100);
        check("reset.sat_hi", 64'(bus.sat_hi), 64'd0);
        bus.en = 1'b1;

        // Resistance count on ch0.
        events(0, 1'b0, 8, "rcount", pc, nc);
        check("rcount.out0", 64'(ch_out(0)), 64'd102);
        check("rcount.pulses", 64'(pc), 64'd2);
        check("rcount.out1", 64'(ch_out(1)), 64'd254);

        // Saturation on ch1.
        bus.resistance = 8'd0;
        events(1, 1'b0, 1, "sat", pc, nc);
        check("sat.out1", 64'(ch_out(1)), 64'd255);
        check("sat.flag", 64'(bus.sat_hi[1]), 64'd1);
        events(1, 1'b0, 4, "sat_hold", pc, nc);
        check("sat.no_step", 64'(pc), 64'd0);
        events(1, 1'b1, 1, "sat_neg", pc, nc);
        check("sat.out1_dn", 64'(ch_out(1)), 64'd254);
        check("sat.neg_pulse", 64'(nc), 64'd1);

        // Cancellation mode on ch2.
        bus.mode = 1'b1; bus.resistance = 8'd3;
        do_init(init_v);
        events(2, 1'b1, 2, "canc", pc, nc);
        events(2, 1'b0, 2, "canc", pc2, nc2);
        check("canc.out2_4", 64'(ch_out(2)), 64'd50);
        check("canc.no_pulse", 64'(pc + nc + pc2 + nc2), 64'd0);
        events(2, 1'b0, 4, "canc", pc, nc);
        check("canc.out2_8", 64'(ch_out(2)), 64'd51);
        check("canc.one_pulse", 64'(pc), 64'd1);

        // Independent counters, same stimulus.
        bus.mode = 1'b0;
        do_init(init_v);
        events(2, 1'b1, 2, "indep", pc, nc);
        events(2, 1'b0, 4, "indep", pc, nc);
        check("indep.out2_6", 64'(ch_out(2)), 64'd51);
        check("indep.one_pulse", 64'(pc), 64'd1);
        events(2, 1'b1, 2, "indep", pc, nc);
        check("indep.out2_dn", 64'(ch_out(2)), 64'd50);
        check("indep.neg_pulse", 64'(nc), 64'd1);

        // Enable and INIT priority on ch0.
        do_init(init_v);
        events(0, 1'b0, 2, "en", pc, nc);
        bus.en = 1'b0;
        events(0, 1'b0, 5, "en_off", pc, nc);
        check("en_off.out0", 64'(ch_out(0)), 64'd100);
        check("en_off.pulses", 64'(pc), 64'd0);
        bus.en = 1'b1;
        bus.in_ss = 4'b0001; bus.sign = '0; init = 1'b1;
        cyc("init_pri");
        init = 1'b0;
        check("init_pri.out0", 64'(ch_out(0)), 64'd100);
        check("init_pri.pulse", 64'(bus.upd_pos), 64'd0);
        events(0, 1'b0, 3, "after_init", pc, nc);
        check("after_init.out0", 64'(ch_out(0)), 64'd100);
        events(0, 1'b0, 1, "after_init", pc, nc);
        check("after_init.step", 64'(ch_out(0)), 64'd101);

        // Lowering resistance below a live count on ch3.
        bus.resistance = 8'd10;
        do_init(init_v);
        events(3, 1'b0, 6, "rchg", pc, nc);
        bus.resistance = 8'd4;
        events(3, 1'b0, 1, "rchg", pc, nc);
        check("rchg.out3", 64'(ch_out(3)), 64'd11);
        check("rchg.pulse", 64'(pc), 64'd1);
        bus.resistance = 8'd0;
        events(3, 1'b0, 10, "r0", pc, nc);
        check("r0.out3", 64'(ch_out(3)), 64'd21);
        check("r0.pulses", 64'(pc), 64'd10);

        // Randomized run against the model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                for (int i = 0; i < M; i++) begin
                    case ($urandom_range(0, 4))
                        0: bus.out_init[i*N +: N] = 8'd0;
                        1: bus.out_init[i*N +: N] = 8'd1;
                        2: bus.out_init[i*N +: N] = 8'd254;
                        3: bus.out_init[i*N +: N] = 8'd255;
                        default: bus.out_init[i*N +: N] = 8'($urandom);
                    endcase
                end
                init = 1'b1;
            end else begin
                init = 1'b0;
            end
            bus.en    = ($urandom_range(0, 7) != 0);
            bus.in_ss = M'($urandom);
            bus.sign  = M'($urandom);
            if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
            if ($urandom_range(0, 15) == 0) bus.resistance = 8'($urandom_range(0, 4));
            cyc("rand");
        end
        init = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nn_smoothgrad_multi.md
# nn_smoothgrad_multi

Multi-channel stochastic parameter integrator for the on-chip training path. Each of M channels holds an N-bit network parameter (weight or bias), consumes one stochastic gradient bit plus sign per clock, and steps the parameter by one LSB only after a programmable number of same-sign gradient events ("resistance"). It generalises the single-parameter smoothing-gradient integrator to M channels, with clean counter reset, configurable saturation bounds, an optional opposing-event cancellation mode, and per-channel update and saturation status. It sits between the backprop sign/stochastic-bit generators and the weight registers that feed the forward SC multipliers.

## Interface
- N, 8, parameter width per channel
- M, 4, channel count
- RW, 8, resistance and counter width
- MAXVAL, 2^N-1, upper saturation bound (unsigned)
- MINVAL, 0, lower saturation bound (unsigned, MINVAL < MAXVAL)
- CLK  in  1  system clock, all state updates on rising edge
- INIT  in  1  synchronous, active-high reset/load; sampled on CLK rising edge
- EN  in  1  global update enable
- IN_SS  in  M  stochastic gradient bit per channel (1 = event)
- SIGN  in  M  gradient sign per channel (0 = positive/increment, 1 = negative/decrement)
- OUT_INIT  in  M*N  initial parameter values, channel i at [i*N +: N]
- RESISTANCE  in  RW  events required per step, shared by all channels
- MODE  in  1  0 = independent counters, 1 = opposing events cancel
- OUT  out  M*N  parameter values, channel i at [i*N +: N]
- UPD_POS  out  M  one-cycle pulse: channel incremented this edge
- UPD_NEG  out  M  one-cycle pulse: channel decremented this edge
- SAT_HI  out  M  channel OUT == MAXVAL
- SAT_LO  out  M  channel OUT == MINVAL

## Operation
- Per channel state: OUT_i (N bits), CP_i and CN_i (RW-bit positive/negative event counters).
- Priority per edge: INIT > !EN > per-channel rules.
- INIT=1: OUT_i <= OUT_INIT slice (clamped to [MINVAL, MAXVAL]), CP_i <= 0, CN_i <= 0, UPD_* <= 0.
- EN=0: all state holds, UPD_* <= 0.
- EN=1, IN_SS[i]=0: channel holds, UPD <= 0.
- EN=1, IN_SS[i]=1, SIGN[i]=0 (positive event):
  - OUT_i == MAXVAL: hold everything (event discarded).
  - MODE=1 and CN_i != 0: CN_i <= CN_i-1, CP_i and OUT_i hold (cancellation).
  - else CP_i >= RESISTANCE: OUT_i <= OUT_i+1, CP_i <= 0, UPD_POS[i] <= 1.
  - else CP_i <= CP_i+1.
- SIGN[i]=1 (negative event): mirror of the above with MINVAL, CN_i/CP_i swapped, OUT_i-1, UPD_NEG[i].
- MODE=0: CP_i and CN_i never affect each other; both persist across sign changes.
- Comparison is >=, so lowering RESISTANCE below a live count fires on the next same-sign event; counters never wrap (max RESISTANCE is 2^RW-1, reached before overflow).
- RESISTANCE=0: every non-saturated event steps OUT.
- Step size is always exactly 1 LSB; OUT never leaves [MINVAL, MAXVAL]; no wrap-around.
- SAT_HI/SAT_LO are combinational compares of registered OUT_i.
- Channels are fully independent except for shared EN, INIT, RESISTANCE, MODE.

## Timing
- All registered outputs update on the CLK edge that samples the triggering inputs; OUT change and its UPD pulse are visible together, one cycle after the inputs are applied.
- UPD_POS[i] and UPD_NEG[i] are never both 1; each is high for exactly one cycle per step.
- SAT flags follow OUT with zero added latency.
- Reset values (after INIT edge): OUT = clamped OUT_INIT, UPD_* = 0, internal counters 0; SAT flags reflect loaded OUT.
- INIT asserted mid-count discards partial counts; no step is emitted on the INIT edge.
- MODE or RESISTANCE changes take effect on the next edge; counters are not cleared.
- Max throughput: one step per channel per RESISTANCE+1 events.

## Test plan
- Resistance count: M=4, RESISTANCE=3, MODE=0, OUT_INIT ch0=100; 8 consecutive positive events on ch0 -> OUT0 = 102, UPD_POS[0] pulses on event 4 and event 8, other channels unchanged.
- Saturation: OUT_INIT ch1=254, MAXVAL=255, RESISTANCE=0, 5 positive events -> OUT1 = 255 after first event, SAT_HI[1]=1, no further UPD_POS, then 1 negative event -> OUT1 = 254, UPD_NEG[1] pulse.
- Cancellation: MODE=1, RESISTANCE=3, ch2 init 50; 2 negative then 2 positive then 4 positive events -> after 4 events OUT2=50 with no pulses; after 8 events OUT2=51, single UPD_POS[2].
- Independent counters: same stimulus with MODE=0 -> OUT2=51 after event 6 (CP reaches 3 on events 3,4,5,6) with one UPD_POS, CN2 retained: 2 further negative events (3rd, 4th) -> OUT2=50.
- Enable/init priority: mid-count (CP0=2, RESISTANCE=3) drive EN=0 with events for 5 cycles -> no change; then INIT=1 with EN=1 and events -> OUT0 = OUT_INIT, no pulse; 3 more events -> no step, 4th -> step.
- Resistance change: CP3=6 with RESISTANCE=10, lower RESISTANCE to 4, one positive event -> OUT3+1 and UPD_POS[3] on that edge; RESISTANCE=0 with IN_SS held 1 for 10 cycles -> 10 consecutive steps.
